// File: rtl/strip_driver.sv
// WS2812-style strip driver: buffers 24-bit GRB pixel words in a FIFO and serialises
// them MSB-first on dout, followed by a low latch gap.
//
// state   | meaning
// S_IDLE  | line low, waiting for show with pixels queued
// S_LOAD  | pop FIFO head into the shift register (one low cycle)
// S_HIGH  | high part of the current bit (T1H for a 1, T0H for a 0)
// S_LOW   | low remainder of the bit; picks next bit, next pixel or latch gap
// S_RESET | low latch gap of RESET_CYC cycles
module strip_driver #(
  parameter int DEPTH     = 16,
  parameter int T0H       = 4,
  parameter int T1H       = 8,
  parameter int TBIT      = 12,
  parameter int RESET_CYC = 600
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [23:0]              wr_data,
  input  logic                     show,
  input  logic                     clr_ovf,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     overflow,
  output logic                     dout
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (RESET_CYC > TBIT) ? RESET_CYC : TBIT;
  localparam int CW   = $clog2(CMAX + 1);

  generate
    if ((DEPTH < 2) || ((1 << AW) != DEPTH))
      $error("strip_driver: DEPTH must be a power of two and at least 2");
    if (!((T0H > 0) && (T0H < T1H) && (T1H < TBIT)))
      $error("strip_driver: bit timing requires 0 < T0H < T1H < TBIT");
    if (RESET_CYC < 1)
      $error("strip_driver: RESET_CYC must be at least 1");
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HIGH,
    S_LOW,
    S_RESET
  } state_t;

  state_t          state;
  logic [23:0]     mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            push;
  logic            pop;
  logic [23:0]     shift;
  logic [4:0]      bitcnt;
  logic [CW-1:0]   cnt;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign busy  = (state != S_IDLE);
  // A write while full is dropped even if LOAD frees a slot in the same cycle.
  assign push  = wr_en && !full;
  assign pop   = (state == S_LOAD);

  function automatic logic [CW-1:0] high_cnt(input logic b);
    return b ? CW'(T1H - 1) : CW'(T0H - 1);
  endfunction

  function automatic logic [CW-1:0] low_cnt(input logic b);
    return b ? CW'(TBIT - T1H - 1) : CW'(TBIT - T0H - 1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      if (wr_en && full)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

  // Timers are down-counters loaded with length-1; the phase ends when they reach zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      shift  <= '0;
      bitcnt <= '0;
      cnt    <= '0;
      dout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          dout <= 1'b0;
          if (show && !empty) state <= S_LOAD;
        end
        S_LOAD: begin
          shift  <= mem[rd_ptr];
          bitcnt <= 5'd23;
          cnt    <= high_cnt(mem[rd_ptr][23]);
          dout   <= 1'b1;
          state  <= S_HIGH;
        end
        S_HIGH: begin
          if (cnt == '0) begin
            cnt   <= low_cnt(shift[23]);
            dout  <= 1'b0;
            state <= S_LOW;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_LOW: begin
          if (cnt == '0) begin
            if (bitcnt != 5'd0) begin
              shift  <= {shift[22:0], 1'b0};
              bitcnt <= bitcnt - 5'd1;
              cnt    <= high_cnt(shift[22]);
              dout   <= 1'b1;
              state  <= S_HIGH;
            end else if (!empty) begin
              state <= S_LOAD;
            end else begin
              cnt   <= CW'(RESET_CYC - 1);
              state <= S_RESET;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_RESET: begin
          dout <= 1'b0;
          if (cnt == '0)
            state <= S_IDLE;
          else
            cnt <= cnt - CW'(1);
        end
        default: begin
          dout  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
